// File: rtl/disp_seq.sv
// Display sequencer: snapshots operands/op on load and drives one registered display word,
// channel picked manually or by timed auto-scroll. Optional op-channel blink via DISP_SEQ_BLINK_EN.
module disp_seq #(
  parameter int unsigned  W           = 16,
  parameter int unsigned  OPW         = 4,
  parameter int unsigned  DWELL       = 50000,
  parameter logic [W-1:0] DEFAULT_VAL = W'('hA),
  parameter int unsigned  BLINK_HALF  = 25000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   save1,
  input  logic [W-1:0]   save2,
  input  logic [OPW-1:0] op,
  input  logic           load,
  input  logic           mode,
  input  logic [1:0]     sel,
  output logic [W-1:0]   display_out,
  output logic [1:0]     chan_idx,
  output logic           valid
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    CH_SAVE1 = 2'b00,
    CH_OP    = 2'b01,
    CH_SAVE2 = 2'b10,
    CH_DEF   = 2'b11
  } chan_e;

  chan_e            idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     snap1_q, snap1_d;
  logic [W-1:0]     snap2_q, snap2_d;
  logic [OPW-1:0]   snapop_q, snapop_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     disp_q, disp_d;
  logic             blank_c;

`ifdef DISP_SEQ_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  // Free-running half-period counter; phase flips on each wrap.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLK_W'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blank_c = phase_d;
`else
  assign blank_c = 1'b0;
`endif

  // Snapshot capture, channel selection/rotation and next display word.
  always_comb begin
    snap1_d  = snap1_q;
    snap2_d  = snap2_q;
    snapop_d = snapop_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    cnt_d    = '0;
    disp_d   = '0;

    if (load) begin
      snap1_d  = save1;
      snap2_d  = save2;
      snapop_d = op;
      valid_d  = 1'b1;
    end

    if (!mode) begin
      idx_d = chan_e'(sel);
    end else if (cnt_q == CNT_W'(DWELL - 1)) begin
      case (idx_q)
        CH_SAVE1: idx_d = CH_OP;
        CH_OP:    idx_d = CH_SAVE2;
        default:  idx_d = CH_SAVE1;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (idx_d)
      CH_SAVE1: disp_d = snap1_d;
      CH_OP:    disp_d = blank_c ? '0 : W'(snapop_d);
      CH_SAVE2: disp_d = snap2_d;
      default:  disp_d = DEFAULT_VAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= CH_SAVE1;
      cnt_q    <= '0;
      snap1_q  <= '0;
      snap2_q  <= '0;
      snapop_q <= '0;
      valid_q  <= 1'b0;
      disp_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      snap1_q  <= snap1_d;
      snap2_q  <= snap2_d;
      snapop_q <= snapop_d;
      valid_q  <= valid_d;
      disp_q   <= disp_d;
    end
  end

  assign display_out = disp_q;
  assign chan_idx    = idx_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_disp_seq.sv
// Scoreboard bench for disp_seq (W=16, OPW=4, DWELL=4, DEFAULT_VAL=000A, BLINK_HALF=3).
module tb_disp_seq;

  logic        clk;
  logic        rst;
  logic [15:0] save1;
  logic [15:0] save2;
  logic [3:0]  op;
  logic        load;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] display_out;
  logic [1:0]  chan_idx;
  logic        valid;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  c;
    logic        v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;

  disp_seq #(
    .W(16), .OPW(4), .DWELL(4), .DEFAULT_VAL(16'h000A), .BLINK_HALF(3)
  ) dut (
    .clk(clk), .rst(rst), .save1(save1), .save2(save2), .op(op), .load(load),
    .mode(mode), .sel(sel), .display_out(display_out), .chan_idx(chan_idx), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expected outputs for the coming edge, then move to the next falling edge.
  task automatic tick(input logic [15:0] d, input logic [1:0] c, input logic v, input string name);
    exp_t e;
    if (rst) k = 0;
    else k++;
`ifdef DISP_SEQ_BLINK_EN
    if (!rst && c == 2'b01 && ((k / 3) % 2 == 1)) d = 16'h0000;
`endif
    e.d = d;
    e.c = c;
    e.v = v;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (display_out !== mon_e.d || chan_idx !== mon_e.c || valid !== mon_e.v) begin
        n_fail++;
        $display("FAIL %s: got disp=%h chan=%0d valid=%0b, want disp=%h chan=%0d valid=%0b",
                 mon_e.name, display_out, chan_idx, valid, mon_e.d, mon_e.c, mon_e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b0; sel = 2'b00;
    save1 = 16'h0; save2 = 16'h0; op = 4'h0;
    @(negedge clk);

    // Reset and DEFAULT_VAL with no load yet
    tick(16'h0000, 2'd0, 1'b0, "reset0");
    tick(16'h0000, 2'd0, 1'b0, "reset1");
    rst = 1'b0; sel = 2'b11;
    tick(16'h000A, 2'd3, 1'b0, "default_preload");

    // Load and manual select; inputs change afterwards to prove the snapshot holds
    save1 = 16'h1234; save2 = 16'h00FF; op = 4'h3; load = 1'b1; sel = 2'b00;
    tick(16'h1234, 2'd0, 1'b1, "load_sel0");
    load = 1'b0; save1 = 16'hFFFF; save2 = 16'hEEEE; op = 4'hF;
    sel = 2'b01; tick(16'h0003, 2'd1, 1'b1, "man_sel1");
    sel = 2'b10; tick(16'h00FF, 2'd2, 1'b1, "man_sel2");
    sel = 2'b00; tick(16'h1234, 2'd0, 1'b1, "man_sel0");

    // Auto-scroll from index 0; sel toggles and must be ignored
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin sel = 2'(i + 1); tick(16'h1234, 2'd0, 1'b1, "auto_ch0"); end
    for (int i = 0; i < 4; i++) begin sel = 2'(i);     tick(16'h0003, 2'd1, 1'b1, "auto_ch1"); end
    for (int i = 0; i < 4; i++) begin sel = 2'(3 - i); tick(16'h00FF, 2'd2, 1'b1, "auto_ch2"); end
    tick(16'h1234, 2'd0, 1'b1, "auto_wrap");
    for (int i = 0; i < 3; i++) tick(16'h1234, 2'd0, 1'b1, "auto_ch0_b");
    for (int i = 0; i < 4; i++) tick(16'h0003, 2'd1, 1'b1, "auto_ch1_b");
    tick(16'h00FF, 2'd2, 1'b1, "auto_ch2_c0");
    tick(16'h00FF, 2'd2, 1'b1, "auto_ch2_c1");

    // Load mid-dwell: new value shows next edge, rotation timing unchanged
    save2 = 16'hBEEF; save1 = 16'h1234; op = 4'h3; load = 1'b1;
    tick(16'hBEEF, 2'd2, 1'b1, "auto_load_beef");
    load = 1'b0; save2 = 16'h0000;
    tick(16'hBEEF, 2'd2, 1'b1, "auto_ch2_c3");
    tick(16'h1234, 2'd0, 1'b1, "auto_after_beef");
    tick(16'h1234, 2'd0, 1'b1, "auto_pre_rst");

    // Reset mid-dwell while mode stays auto
    rst = 1'b1; tick(16'h0000, 2'd0, 1'b0, "rst_mid_dwell");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(16'h0000, 2'd0, 1'b0, "post_rst_dwell");
    tick(16'h0000, 2'd1, 1'b0, "post_rst_adv");
    save1 = 16'h1234; save2 = 16'h00FF; op = 4'h3; load = 1'b1;
    tick(16'h0003, 2'd1, 1'b1, "auto_reload");
    load = 1'b0;

    // Auto -> manual sel=11, then back to auto from index 3
    mode = 1'b0; sel = 2'b11; tick(16'h000A, 2'd3, 1'b1, "to_manual_def");
    mode = 1'b1; sel = 2'b01;
    for (int i = 0; i < 3; i++) tick(16'h000A, 2'd3, 1'b1, "auto_from_idx3");
    tick(16'h1234, 2'd0, 1'b1, "idx3_adv_to0");
    mode = 1'b0; sel = 2'b10; tick(16'h00FF, 2'd2, 1'b1, "to_manual_sel2");
    sel = 2'b01; tick(16'h0003, 2'd1, 1'b1, "man_sel1_b");

    // Load together with a channel change
    sel = 2'b00; save1 = 16'h5555; load = 1'b1;
    tick(16'h5555, 2'd0, 1'b1, "load_and_switch");
    load = 1'b0;

    // Op channel held on a fixed phase from reset (blinks only in the blink build)
    rst = 1'b1; tick(16'h0000, 2'd0, 1'b0, "rst_blink");
    rst = 1'b0; save1 = 16'h1234; save2 = 16'h00FF; op = 4'h3; load = 1'b1; sel = 2'b01;
    tick(16'h0003, 2'd1, 1'b1, "op_ch_k1");
    load = 1'b0;
    for (int i = 0; i < 8; i++) tick(16'h0003, 2'd1, 1'b1, "op_ch_steady");
    sel = 2'b00;
    for (int i = 0; i < 4; i++) tick(16'h1234, 2'd0, 1'b1, "ch0_no_blink");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
